// File: rtl/seven_seg_scan_driver_if.sv
// Load/display bundle for the multiplexed 7-segment scan driver.
// The master drives the load side, and the driver (slave) returns the segment and anode lines.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4
) ();
  logic                    load;
  logic [4*NUM_DIGITS-1:0] number;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    lz_en;
  logic [PWM_BITS-1:0]     brightness;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;
  logic                    pending;

  modport master (
    output load, number, dp_in, lz_en, brightness,
    input  seg_out, dp_out, an, frame_start, pending
  );

  modport slave (
    input  load, number, dp_in, lz_en, brightness,
    output seg_out, dp_out, an, frame_start, pending
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode hex display driver with a guard band, PWM dimming,
// leading-zero blanking and a double-buffered load that commits at frame boundaries.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 125000,
  parameter int PWM_BITS   = 4,
  parameter int GUARD      = 64
) (
  input logic                     clk,
  input logic                     rst_n,
  seven_seg_scan_driver_if.slave  bus
);
  localparam int SLOT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int NUM_W  = 4 * NUM_DIGITS;

  logic [SLOT_W-1:0]     slot_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [NUM_W-1:0]      num_s, num_c;
  logic [NUM_DIGITS-1:0] dp_s, dp_c;
  logic                  lz_s, lz_c;
  logic [PWM_BITS-1:0]   br_s, br_c;
  logic                  pend;
  logic                  slot_wrap, boundary, commit;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            nib_p0;
  logic [6:0]            seg_p0, seg_p1;
  logic                  dp_p0, dp_p1;
  logic [NUM_DIGITS-1:0] an_p0, an_p1;
  logic                  frame_p1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  assign slot_wrap = (slot_cnt == SLOT_W'(TICK_DIV - 1));
  assign boundary  = slot_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign commit    = boundary && pend;

  // Stage p0: blanking mask, decode and anode gating from the current scan state
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank      = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (num_c[4*i +: 4] == 4'h0);
      blank[i]   = lz_c && zero_above;
    end
  end

  always_comb begin
    nib_p0 = num_c[4*int'(digit_idx) +: 4];
    seg_p0 = blank[digit_idx] ? 7'h7F : hex_to_seg(nib_p0);
    dp_p0  = ~dp_c[digit_idx];
    an_p0  = '1;
    if ((slot_cnt >= SLOT_W'(GUARD)) && (pwm_cnt < br_c))
      an_p0 = ~(NUM_DIGITS'(1) << digit_idx);
  end

  // Stage p1: counters, shadow/commit buffering and registered display lines
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      pwm_cnt   <= '0;
      digit_idx <= '0;
      num_s     <= '0;
      dp_s      <= '0;
      lz_s      <= 1'b0;
      br_s      <= '0;
      num_c     <= '0;
      dp_c      <= '0;
      lz_c      <= 1'b0;
      br_c      <= '0;
      pend      <= 1'b0;
      seg_p1    <= 7'h7F;
      dp_p1     <= 1'b1;
      an_p1     <= '1;
      frame_p1  <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
      pwm_cnt  <= pwm_cnt + 1'b1;
      if (slot_wrap)
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
      // Commit reads the old shadow even when a load lands on the same edge
      if (commit) begin
        num_c <= num_s;
        dp_c  <= dp_s;
        lz_c  <= lz_s;
        br_c  <= br_s;
      end
      if (bus.load) begin
        num_s <= bus.number;
        dp_s  <= bus.dp_in;
        lz_s  <= bus.lz_en;
        br_s  <= bus.brightness;
        pend  <= 1'b1;
      end else if (commit) begin
        pend  <= 1'b0;
      end
      seg_p1   <= seg_p0;
      dp_p1    <= dp_p0;
      an_p1    <= an_p0;
      frame_p1 <= boundary;
    end
  end

  assign bus.seg_out     = seg_p1;
  assign bus.dp_out      = dp_p1;
  assign bus.an          = an_p1;
  assign bus.frame_start = frame_p1;
  assign bus.pending     = pend;
endmodule
